// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle for alu_seq_ctrl; the abort signal exists only when
// ALU_SEQ_ABORT_EN is defined.
interface alu_seq_ctrl_if;
   logic       start;
   logic [1:0] op;
   logic [2:0] count;
   logic [3:0] din;
`ifdef ALU_SEQ_ABORT_EN
   logic       abort;
`endif
   logic [3:0] sel;
   logic       busy;
   logic       done;
   logic [3:0] result;

   modport master (
      output start, op, count, din,
`ifdef ALU_SEQ_ABORT_EN
      output abort,
`endif
      input  sel, busy, done, result
   );

   modport slave (
      input  start, op, count, din,
`ifdef ALU_SEQ_ABORT_EN
      input  abort,
`endif
      output sel, busy, done, result
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequenced 4-bit rotate/shift controller: applies `count` single-bit steps to din.
// Optional feature: define ALU_SEQ_ABORT_EN to add the abort input.
module alu_seq_ctrl (
   input  logic                 clk_i,
   input  logic                 rst_i,
   alu_seq_ctrl_if.slave        bus_io
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e     state_q, state_d;
   logic [3:0] work_q, work_d;
   logic [2:0] cnt_q, cnt_d;
   logic [1:0] opr_q, opr_d;

   function automatic logic [3:0] step_f(input logic [3:0] w, input logic [1:0] o);
      logic [3:0] r;
      unique case (o)
         2'b00:   r = {w[2:0], w[3]};
         2'b01:   r = {w[0], w[3:1]};
         2'b10:   r = {w[2:0], 1'b0};
         default: r = {1'b0, w[3:1]};
      endcase
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      opr_d   = opr_q;
      unique case (state_q)
         StIdle: begin
            if (bus_io.start) begin
               work_d  = bus_io.din;
               opr_d   = bus_io.op;
               cnt_d   = bus_io.count;
               state_d = (bus_io.count != 3'd0) ? StRun : StDone;
            end
         end
         StRun: begin
`ifdef ALU_SEQ_ABORT_EN
            if (bus_io.abort) begin
               // Keep the partial result; no step on the abort edge.
               state_d = StIdle;
               cnt_d   = 3'd0;
            end else begin
               work_d = step_f(work_q, opr_q);
               cnt_d  = cnt_q - 3'd1;
               if (cnt_q == 3'd1) state_d = StDone;
            end
`else
            work_d = step_f(work_q, opr_q);
            cnt_d  = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = StDone;
`endif
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         work_q  <= 4'b0000;
         cnt_q   <= 3'b000;
         opr_q   <= 2'b00;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         opr_q   <= opr_d;
      end
   end

   // Outputs depend only on registered state, never on inputs.
   always_comb begin
      bus_io.busy   = (state_q != StIdle);
      bus_io.done   = (state_q == StDone);
      bus_io.sel    = (state_q == StRun) ? {2'b01, opr_q} : 4'b0000;
      bus_io.result = work_q;
   end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed cases, randomized requests against
// an arithmetic reference model, reset mid-run and (with ALU_SEQ_ABORT_EN) abort.
module tb_alu_seq_ctrl;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One step on a 4-bit value, expressed as plain arithmetic.
   function automatic int ref_step(input int op, input int w);
      case (op)
         0:       return ((w * 2) % 16) + (w / 8);
         1:       return (w / 2) + ((w % 2) * 8);
         2:       return (w * 2) % 16;
         default: return w / 2;
      endcase
   endfunction

   // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
   task automatic run_op(input int op, input int din, input int cnt, input bit hold,
                         output int fin);
      int w;
      int exp_sel;
      w = din;
      bus.start = 1'b1;
      bus.op    = 2'(op);
      bus.din   = 4'(din);
      bus.count = 3'(cnt);
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      else begin
         // Garbage while busy must be ignored.
         bus.op    = 2'($urandom);
         bus.din   = 4'($urandom);
         bus.count = 3'($urandom);
      end
      for (int k = 0; k <= cnt; k++) begin
         if (k > 0) begin
            @(posedge clk);
            @(negedge clk);
         end
         exp_sel = (k < cnt) ? (4 + op) : 0;
         checks++;
         if (bus.result !== 4'(w)) begin
            errors++;
            $display("FAIL step_result op=%0d k=%0d: got %b want %b", op, k, bus.result, 4'(w));
         end
         checks++;
         if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL step_busy op=%0d k=%0d: got %b want 1", op, k, bus.busy);
         end
         checks++;
         if (bus.done !== (k == cnt)) begin
            errors++;
            $display("FAIL step_done op=%0d k=%0d: got %b want %b", op, k, bus.done, k == cnt);
         end
         checks++;
         if (bus.sel !== 4'(exp_sel)) begin
            errors++;
            $display("FAIL step_sel op=%0d k=%0d: got %b want %b", op, k, bus.sel, 4'(exp_sel));
         end
         if (k < cnt) w = ref_step(op, w);
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sel !== 4'b0000
          || bus.result !== 4'(w)) begin
         errors++;
         $display("FAIL end_state: got busy=%b done=%b sel=%b result=%b want 0 0 0000 %b",
                  bus.busy, bus.done, bus.sel, bus.result, 4'(w));
      end
      fin = w;
   endtask

   task automatic test_reset();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sel !== 4'b0000
          || bus.result !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b sel=%b result=%b want 0 0 0000 0000",
                  bus.busy, bus.done, bus.sel, bus.result);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      int fin;
      run_op(0, 4'b1001, 1, 1'b0, fin);
      checks++;
      if (bus.result !== 4'b0011) begin
         errors++;
         $display("FAIL rol1: got %b want 0011", bus.result);
      end
      run_op(1, 4'b0001, 3, 1'b0, fin);
      checks++;
      if (bus.result !== 4'b0010) begin
         errors++;
         $display("FAIL ror3: got %b want 0010", bus.result);
      end
      run_op(2, 4'b1111, 5, 1'b0, fin);
      checks++;
      if (bus.result !== 4'b0000) begin
         errors++;
         $display("FAIL shl5: got %b want 0000", bus.result);
      end
      run_op(0, 4'b1010, 4, 1'b0, fin);
      checks++;
      if (bus.result !== 4'b1010) begin
         errors++;
         $display("FAIL rol4: got %b want 1010", bus.result);
      end
      run_op(3, 4'b1010, 0, 1'b0, fin);
      checks++;
      if (bus.result !== 4'b1010) begin
         errors++;
         $display("FAIL shr0: got %b want 1010", bus.result);
      end
   endtask

   task automatic test_idle_hold();
      logic [3:0] held;
      held = bus.result;
      for (int i = 0; i < 4; i++) begin
         bus.din = 4'($urandom);
         bus.op  = 2'($urandom);
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.result !== held || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: got result=%b busy=%b done=%b want %b 0 0",
                     bus.result, bus.busy, bus.done, held);
         end
      end
   endtask

   task automatic test_random();
      int fin;
      for (int i = 0; i < 30; i++) begin
         run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 7)), 1'b0, fin);
      end
   endtask

   task automatic test_back_to_back();
      int fin;
      run_op(1, 4'b0110, 2, 1'b1, fin);
      run_op(2, 4'b0011, 3, 1'b1, fin);
      run_op(0, 4'b1000, 1, 1'b0, fin);
   endtask

   task automatic test_reset_mid_run();
      int fin;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.din   = 4'b0101;
      bus.count = 3'd6;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sel !== 4'b0000
          || bus.result !== 4'b0000) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b sel=%b result=%b want 0 0 0000 0000",
                  bus.busy, bus.done, bus.sel, bus.result);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got done=%b busy=%b want 0 0", bus.done, bus.busy);
         end
      end
      run_op(3, 4'b1100, 2, 1'b0, fin);
   endtask

`ifdef ALU_SEQ_ABORT_EN
   task automatic test_abort();
      int fin;
      bus.start = 1'b1;
      bus.op    = 2'b00;
      bus.din   = 4'b0001;
      bus.count = 3'd4;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.abort = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.result !== 4'b0100 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort: got result=%b busy=%b done=%b want 0100 0 0",
                     bus.result, bus.busy, bus.done);
         end
         @(posedge clk);
         @(negedge clk);
      end
      // Abort in IDLE alongside start must not block acceptance.
      bus.abort = 1'b1;
      run_op(2, 4'b0111, 0, 1'b0, fin);
      bus.abort = 1'b0;
   endtask
`endif

   initial begin
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'b00;
      bus.din   = 4'b0000;
      bus.count = 3'd0;
`ifdef ALU_SEQ_ABORT_EN
      bus.abort = 1'b0;
`endif
      #1;
      test_reset();
      test_directed();
      test_idle_hold();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
`ifdef ALU_SEQ_ABORT_EN
      test_abort();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset: clk input 1 (rising-edge clock); Reset input 1 (asynchronous, active-high).
REQ-002 The block SHALL have the following other ports:
- start  input  1: request; sampled only in IDLE.
- op  input  2: 00 ROL, 01 ROR, 10 SHL, 11 SHR.
- count  input  3: number of single-bit steps, 0..7.
- din  input  4: operand.
- sel  output  4: step code driven to the ALU register during RUN.
- busy  output  1: 1 whenever state is not IDLE.
- done  output  1: one-cycle completion pulse.
- result  output  4: working register.
REQ-003 When ALU_SEQ_ABORT_EN is defined, the block SHALL add port abort  input  1: cancel the operation in progress.

Function
REQ-004 The block SHALL be an FSM with states IDLE, RUN and DONE, and SHALL hold registers work[3:0], cnt[2:0] and opr[1:0].
REQ-005 In IDLE with start=1, the block SHALL on that edge (E0) load work<=din, opr<=op and cnt<=count; it SHALL go to RUN if count!=0, else to DONE.
REQ-006 In IDLE with start=0, the block SHALL hold all registers.
REQ-007 In RUN, each edge SHALL apply one step to work per opr and decrement cnt:
- ROL: {w[2:0],w[3]}
- ROR: {w[0],w[3:1]}
- SHL: {w[2:0],0}
- SHR: {0,w[3:1]}
REQ-008 The block SHALL leave RUN for DONE on the edge where cnt decrements from 1 to 0; exactly count steps SHALL be applied.
REQ-009 The block SHALL assert done only in DONE, for exactly one cycle: from edge E0+count until E0+count+1. DONE SHALL always go to IDLE on the next edge.
REQ-010 busy SHALL be high for count+1 cycles per accepted request.
REQ-011 start SHALL be ignored in RUN and DONE; requests are not queued, and a start held high is accepted again on the first IDLE cycle.
REQ-012 sel SHALL be combinational from state and opr:
- RUN with ROL: 0100
- RUN with ROR: 0101
- RUN with SHL: 0110
- RUN with SHR: 0111
- any other state: 0000
REQ-013 result SHALL equal work at all times; it SHALL change only on a capture edge or a step edge, and hold its value in DONE and IDLE.
REQ-014 count of 4 or more SHALL be honoured literally: ROL/ROR by 4 returns din, and SHL/SHR by 4 or more returns 0000.
REQ-015 The block SHALL contain no combinational path from inputs to busy, done or result.

Reset
REQ-016 Reset=1 SHALL, immediately and independently of clk, force:
- state=IDLE
- work=0000
- cnt=000
- opr=00
- busy=0, done=0, sel=0000, result=0000
REQ-017 Reset asserted mid-RUN or in DONE SHALL discard the operation with no done pulse.
REQ-018 On the first edge after Reset deasserts, the block SHALL be in IDLE and able to accept start.

Configuration
REQ-019 With ALU_SEQ_ABORT_EN defined, abort=1 in RUN SHALL on the next edge go to IDLE, clear cnt, keep work as the partial result of the steps already applied, and produce no done pulse.
REQ-020 With ALU_SEQ_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE, and abort together with start in IDLE SHALL still accept start.
REQ-021 Without ALU_SEQ_ABORT_EN, the abort port and its logic SHALL be absent, and RUN SHALL always complete.

Verification
REQ-022 Bench SHALL cover ROL: start, op=00, din=1001, count=1 -> sel=0100 for 1 cycle; done 1 cycle after E0; result=0011; busy 2 cycles.
REQ-023 Bench SHALL cover ROR: op=01, din=0001, count=3 -> step values 1000, 0100, 0010; final result=0010; done at E0+3.
REQ-024 Bench SHALL cover shift past width: op=10, din=1111, count=5 -> result=0000 at done; and op=00, din=1010, count=4 -> result=1010.
REQ-025 Bench SHALL cover count=0: op=11, din=1010, count=0 -> DONE directly at E0+0; sel stays 0000; result=1010; done pulse of 1 cycle.
REQ-026 Bench SHALL cover Reset mid-RUN: Reset pulsed between clock edges during ROL count=6 -> outputs zero before the next edge; no done; new start accepted afterwards.
REQ-027 With ALU_SEQ_ABORT_EN defined, bench SHALL cover abort: op=00, din=0001, count=4, abort after 2 steps -> result=0100, busy low, no done pulse.
